// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: sends one 32-bit word as four byte frames, LSB byte first.
// Each frame is start + 8 data bits (LSB first) + optional even parity + 1 or 2 stop bits.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic        rclk,
    input  logic        rrst,
    input  logic [31:0] TX_IN_DATA,
    input  logic        start_tx,
    output logic        tx_busy,
    output logic        TX_OUT,
    output logic        tx_done,
    output logic [1:0]  byte_idx
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic StopLast = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end;

    assign bit_end = (baud_q == BaudLast);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        baud_d     = (state_q == StIdle || bit_end) ? '0 : baud_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!start_tx) begin
                    state_d    = StStart;
                    shift_d    = TX_IN_DATA;
                    byte_idx_d = 2'd0;
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    baud_d     = '0;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            tx_d    = ^shift_q[7:0];
                        end else begin
                            state_d    = StStop;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[bit_cnt_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d    = StStop;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (stop_cnt_q == StopLast) begin
                        if (byte_idx_q == 2'd3) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            tx_d    = 1'b1;
                        end else begin
                            // Next byte follows immediately with its start bit.
                            state_d    = StStart;
                            byte_idx_d = byte_idx_q + 2'd1;
                            shift_d    = {8'd0, shift_q[31:8]};
                            tx_d       = 1'b0;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            byte_idx_q <= 2'd0;
            bit_cnt_q  <= 3'd0;
            baud_q     <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_q     <= baud_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // Busy includes the strobe cycle so the FIFO cannot pop twice before the load registers.
    assign tx_busy  = (state_q != StIdle) || !start_tx;
    assign TX_OUT   = tx_q;
    assign tx_done  = done_q;
    assign byte_idx = byte_idx_q;

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer that sits directly downstream of the TX FIFO. It accepts one 32-bit word per `start_tx` strobe from the FIFO read side and shifts it out on a single serial line as four asynchronous byte frames, least-significant byte first. Each frame is start + 8 data bits (LSB first) + optional even parity + 1 or 2 stop bits. It drives `tx_busy` back to the FIFO so that exactly one word is popped per transmission.

## Interface
- `CLKS_PER_BIT`, 868, rclk cycles per serial bit (≥2; 868 = 100 MHz / 115200).
- `PARITY_EN`, 0, 1 = append even-parity bit after data bits.
- `STOP_BITS`, 1, number of stop bits (1 or 2).
- `rclk`  in  1  sole clock (FIFO read-side clock).
- `rrst`  in  1  reset, synchronous, active-low.
- `TX_IN_DATA`  in  32  word from FIFO; valid in the cycle `start_tx` is low.
- `start_tx`  in  1  active-low one-cycle load strobe from FIFO.
- `tx_busy`  out  1  high while a word is in flight or being accepted.
- `TX_OUT`  out  1  serial line, idle high, registered.
- `tx_done`  out  1  one-cycle pulse when the last stop bit of byte 3 completes.
- `byte_idx`  out  2  index of the byte currently on the line (0..3).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: at a rclk edge with `rrst`=1 and `start_tx`=0, latch `TX_IN_DATA` into a 32-bit shift register, clear `byte_idx`, bit and baud counters, and drive `TX_OUT`=0.
- START → DATA after `CLKS_PER_BIT` cycles; DATA holds bit `byte[bit_cnt]`, bit_cnt 0..7.
- DATA → PARITY (`PARITY_EN`=1) or STOP after bit 7. The parity bit is the XOR of the 8 data bits (even parity).
- STOP lasts `STOP_BITS`×`CLKS_PER_BIT` cycles with `TX_OUT`=1. Then:
  - if `byte_idx`<3: increment `byte_idx`, shift the data right by 8, go to START;
  - otherwise go to IDLE with `tx_done`=1.
- Baud counter: 0..`CLKS_PER_BIT`-1, wraps at each bit boundary. Every bit, including each stop bit, lasts exactly `CLKS_PER_BIT` cycles.
- `tx_busy` = (state≠IDLE) OR (`start_tx`=0), combinational from the input. This blocks the FIFO from popping a second word in the cycle before the serializer registers the first.
- `start_tx`=0 while not IDLE is ignored; the latched word is unaffected.
- Zero-padded upper bytes from the FIFO are transmitted as 0x00 frames.
- Reset values (`rrst`=0 at an edge): state IDLE, `TX_OUT`=1, `tx_busy`=0 (when `start_tx`=1), `tx_done`=0, `byte_idx`=0, counters 0, shift register 0.
- Reset mid-frame aborts at the next edge: line returns high and the remaining bytes are dropped.
- Reset has priority over a simultaneous `start_tx`.

## Timing
- Let S be the accepting edge. `TX_OUT` falls to 0 at S, with 0-cycle latency from sampling.
- Bit n of the frame begins at S + n·`CLKS_PER_BIT`.
- Frame length F = (10 + `PARITY_EN` + `STOP_BITS` − 1)·`CLKS_PER_BIT` cycles.
- Byte k start bit begins at S + k·F. No idle gap between bytes of one word.
- `tx_done` high and `tx_busy` low from edge S + 4F. `tx_done` lasts exactly one cycle.
- Back-to-back words: the FIFO pops at S+4F+1 and the serializer accepts at S+4F+2. `TX_OUT` stays high for 2 cycles between words.

## Test plan
- Reset: hold `rrst`=0 for 3 cycles with `start_tx`=0 → `TX_OUT`=1, `tx_done`=0, `byte_idx`=0, state stays IDLE; `tx_busy`=1 only via `start_tx`.
- Single word (`CLKS_PER_BIT`=4, no parity, 1 stop), `TX_IN_DATA`=0x000000A5 → line 0,1,0,1,0,0,1,0,1,1 (4 cycles each), then three 0x00 frames. `tx_done` pulses at S+160.
- Parity (`PARITY_EN`=1), word 0x00000307 → byte 0x07 parity bit 1, byte 0x03 parity bit 0, bytes 2–3 parity 0. F=44, `tx_done` at S+176.
- `STOP_BITS`=2, word 0xFFFFFFFF → each frame ends with 8 high cycles. Total 176 cycles. `byte_idx` steps 0→1→2→3 at S+44, S+88, S+132.
- Busy handshake: drive `start_tx`=0 for 1 cycle, then again 5 cycles later mid-frame → `tx_busy` high in the strobe cycle, second strobe ignored, word unchanged, only one `tx_done`.
- Reset mid-byte-1 (at S+50) → `TX_OUT`=1 at the next edge, `byte_idx`=0, `tx_busy`=0. A new word strobed afterwards transmits correctly from byte 0.
